k_input_debounce: RTL and testbench

K_INPUT_DEBOUNCE -- requirements
Module: k_input_debounce

---
 rtl/k_input_debounce.sv | 105 ++++++++++
 tb/tb_k_input_debounce.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/k_input_debounce.sv
`default_nettype none
// ============================================================================
// k_input_debounce : synchronises and debounces four K buttons on a shared
//                    sample tick that doubles as the CPU clock-enable.
// Rev 1.0
// ============================================================================
module k_input_debounce #(
   parameter int TICK_DIV       = 40,
   parameter int DEBOUNCE_TICKS = 16,
   parameter bit ACTIVE_LOW     = 1'b1
) (
   input  logic       raw_clk,
   input  logic       button_reset,
   input  logic [3:0] pin_k_raw,
   output logic [3:0] pins_k,
   output logic       k_nonzero,
   output logic       k_change,
   output logic       tick
);

   localparam int DW = $clog2(TICK_DIV);
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

   localparam logic [3:0]    c_IDLE_LVL = ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [DW-1:0] c_DIV_LAST = DW'(TICK_DIV - 1);
   localparam logic [CW-1:0] c_CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

   logic [3:0]          r_sync1;
   logic [3:0]          r_sync2;
   logic [3:0]          w_s;
   logic [DW-1:0]       r_div;
   logic                w_tick;
   logic [3:0][CW-1:0]  r_cnt;
   logic [3:0][CW-1:0]  w_cnt_nxt;
   logic [3:0]          r_pins;
   logic [3:0]          w_pins_nxt;
   logic                r_nz;
   logic                r_chg;

   // Synchronizer resets to the idle pin level so reset never looks like a press.
   always_ff @(posedge raw_clk or negedge button_reset) begin
      if (!button_reset) begin
         r_sync1 <= c_IDLE_LVL;
         r_sync2 <= c_IDLE_LVL;
      end else begin
         r_sync1 <= pin_k_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = ACTIVE_LOW ? ~r_sync2 : r_sync2;

   assign w_tick = (r_div == c_DIV_LAST);

   always_ff @(posedge raw_clk or negedge button_reset) begin
      if (!button_reset) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // A bit matching its accepted level clears its count even off-tick, so any
   // glitch back to the accepted level restarts the debounce interval.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_pins_nxt = r_pins;
      for (int n = 0; n < 4; n++) begin
         if (w_s[n] == r_pins[n]) begin
            w_cnt_nxt[n] = '0;
         end else if (w_tick) begin
            if (r_cnt[n] >= c_CNT_LAST) begin
               w_pins_nxt[n] = w_s[n];
               w_cnt_nxt[n]  = '0;
            end else begin
               w_cnt_nxt[n] = r_cnt[n] + 1'b1;
            end
         end
      end
   end

   // Flags derive from the next value so they line up with pins_k exactly.
   always_ff @(posedge raw_clk or negedge button_reset) begin
      if (!button_reset) begin
         r_cnt  <= '0;
         r_pins <= '0;
         r_nz   <= 1'b0;
         r_chg  <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_pins <= w_pins_nxt;
         r_nz   <= |w_pins_nxt;
         r_chg  <= (w_pins_nxt != r_pins);
      end
   end

   assign pins_k    = r_pins;
   assign k_nonzero = r_nz;
   assign k_change  = r_chg;
   assign tick      = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_k_input_debounce.sv
`default_nettype none
// Directed bench for k_input_debounce with TICK_DIV=4, DEBOUNCE_TICKS=3, ACTIVE_LOW=1.
module tb_k_input_debounce;

   logic       raw_clk      = 1'b0;
   logic       button_reset = 1'b1;
   logic [3:0] pin_k_raw    = 4'hF;
   logic [3:0] pins_k;
   logic       k_nonzero;
   logic       k_change;
   logic       tick;

   int checks = 0;
   int errors = 0;

   always #5 raw_clk = ~raw_clk;

   k_input_debounce #(
      .TICK_DIV       (4),
      .DEBOUNCE_TICKS (3),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .raw_clk      (raw_clk),
      .button_reset (button_reset),
      .pin_k_raw    (pin_k_raw),
      .pins_k       (pins_k),
      .k_nonzero    (k_nonzero),
      .k_change     (k_change),
      .tick         (tick)
   );

   task automatic cyc();
      @(posedge raw_clk);
      @(negedge raw_clk);
   endtask

   task automatic test_reset();
      logic exp_t;
      button_reset = 1'b0;
      pin_k_raw    = 4'hF;
      repeat (3) @(negedge raw_clk);
      checks++; if (pins_k !== 4'h0) begin errors++; $display("FAIL reset_pins: got %h expected 0", pins_k); end
      checks++; if (k_nonzero !== 1'b0) begin errors++; $display("FAIL reset_nz: got %b expected 0", k_nonzero); end
      checks++; if (k_change !== 1'b0) begin errors++; $display("FAIL reset_chg: got %b expected 0", k_change); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
      button_reset = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         exp_t = ((i % 4) == 3);
         checks++;
         if (tick !== exp_t) begin errors++; $display("FAIL tick_cycle%0d: got %b expected %b", i, tick, exp_t); end
      end
   endtask

   task automatic test_press();
      int lat = 0; int pulses = 0; int bad = 0; logic nz_at = 1'b0;
      pin_k_raw = 4'hE;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (k_change === 1'b1) pulses++;
         if (pins_k !== 4'h0 && pins_k !== 4'h1) bad++;
         if (lat == 0 && pins_k === 4'h1) begin lat = i; nz_at = k_nonzero; end
      end
      checks++; if (lat < 11 || lat > 15) begin errors++; $display("FAIL press_latency: got %0d expected 11..15", lat); end
      checks++; if (pins_k !== 4'h1) begin errors++; $display("FAIL press_pins: got %h expected 1", pins_k); end
      checks++; if (nz_at !== 1'b1) begin errors++; $display("FAIL press_nz_same_cycle: got %b expected 1", nz_at); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL press_pulses: got %0d expected 1", pulses); end
      checks++; if (bad != 0) begin errors++; $display("FAIL press_value: got %0d bad cycles expected 0", bad); end
   endtask

   task automatic test_release_single();
      int lat = 0; int pulses = 0;
      pin_k_raw = 4'hF;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (k_change === 1'b1) pulses++;
         if (lat == 0 && pins_k === 4'h0) lat = i;
      end
      checks++; if (lat < 11 || lat > 15) begin errors++; $display("FAIL rel1_latency: got %0d expected 11..15", lat); end
      checks++; if (k_nonzero !== 1'b0) begin errors++; $display("FAIL rel1_nz: got %b expected 0", k_nonzero); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL rel1_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_glitch();
      int ticks = 0; int pulses = 0; int bad = 0;
      pin_k_raw = 4'hE;
      cyc();
      cyc();
      for (int g = 0; g < 20 && ticks < 2; g++) begin
         if (tick === 1'b1) ticks++;
         if (k_change === 1'b1) pulses++;
         if (pins_k !== 4'h0) bad++;
         if (ticks < 2) cyc();
      end
      checks++; if (ticks != 2) begin errors++; $display("FAIL glitch_ticks: got %0d expected 2", ticks); end
      pin_k_raw = 4'hF;
      cyc();
      checks++; if (dut.r_cnt[0] !== 2'd2) begin errors++; $display("FAIL glitch_peak_cnt: got %0d expected 2", dut.r_cnt[0]); end
      for (int i = 0; i < 12; i++) begin
         if (k_change === 1'b1) pulses++;
         if (pins_k !== 4'h0) bad++;
         cyc();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL glitch_pins: got %0d nonzero cycles expected 0", bad); end
      checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulses); end
      checks++; if (dut.r_cnt[0] !== 2'd0) begin errors++; $display("FAIL glitch_cnt_clear: got %0d expected 0", dut.r_cnt[0]); end
   endtask

   task automatic test_multi(input logic [3:0] raw, input logic [3:0] exp_k, input string tag);
      int lat = 0; int pulses = 0; int bad = 0;
      pin_k_raw = raw;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (k_change === 1'b1) pulses++;
         if (pins_k !== 4'h0 && pins_k !== 4'h9) bad++;
         if (lat == 0 && pins_k === exp_k) lat = i;
      end
      checks++; if (lat < 11 || lat > 15) begin errors++; $display("FAIL %s_latency: got %0d expected 11..15", tag, lat); end
      checks++; if (pins_k !== exp_k) begin errors++; $display("FAIL %s_pins: got %h expected %h", tag, pins_k, exp_k); end
      checks++; if (k_nonzero !== (exp_k != 4'h0)) begin errors++; $display("FAIL %s_nz: got %b expected %b", tag, k_nonzero, (exp_k != 4'h0)); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL %s_pulses: got %0d expected 1", tag, pulses); end
      checks++; if (bad != 0) begin errors++; $display("FAIL %s_intermediate: got %0d bad cycles expected 0", tag, bad); end
   endtask

   task automatic test_reset_mid();
      int lat = 0; int pulses = 0; int bad = 0; logic found = 1'b0;
      pin_k_raw = 4'hE;
      for (int i = 0; i < 20 && pins_k !== 4'h1; i++) cyc();
      checks++; if (pins_k !== 4'h1) begin errors++; $display("FAIL rstmid_setup: got %h expected 1", pins_k); end
      pin_k_raw = 4'hC;
      for (int i = 0; i < 20 && !found; i++) begin
         cyc();
         if (dut.r_cnt[1] === 2'd2) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_cnt2: got timeout expected counter 2"); end
      button_reset = 1'b0;
      #1;
      checks++; if (pins_k !== 4'h0) begin errors++; $display("FAIL rstmid_pins: got %h expected 0", pins_k); end
      checks++; if (k_nonzero !== 1'b0) begin errors++; $display("FAIL rstmid_nz: got %b expected 0", k_nonzero); end
      checks++; if (dut.r_cnt[1] !== 2'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d expected 0", dut.r_cnt[1]); end
      @(negedge raw_clk);
      @(negedge raw_clk);
      button_reset = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (k_change === 1'b1) pulses++;
         if (pins_k !== 4'h0 && pins_k !== 4'h3) bad++;
         if (lat == 0 && pins_k === 4'h3) lat = i;
      end
      checks++; if (lat != 12) begin errors++; $display("FAIL rstmid_reaccept: got %0d cycles expected 12", lat); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 1", pulses); end
      checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_intermediate: got %0d bad cycles expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_press();
      test_release_single();
      test_glitch();
      test_multi(4'h6, 4'h9, "multi_press");
      test_multi(4'hF, 4'h0, "multi_release");
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
